// File: rtl/sat_bin_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sat_bin_pkg
// Description : Shared types and default widths for the SAT bin scheduler:
//               scheduler state encoding, walk direction encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sat_bin_pkg;

  localparam int unsigned c_DEF_WIDTH_BIN_ID = 10;
  localparam int unsigned c_DEF_WIDTH_LVL    = 16;

  // Scheduler states; DONE_SAT / DONE_UNSAT are single-cycle exits to IDLE.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    RUN        = 3'd2,
    STORE      = 3'd3,
    BKT_GBL    = 3'd4,
    DONE_SAT   = 3'd5,
    DONE_UNSAT = 3'd6
  } state_e;

  // What to do once the current bin has been written back.
  typedef enum logic [0:0] {
    DIR_FWD = 1'b0,
    DIR_BKT = 1'b1
  } dir_e;

endpackage
`default_nettype wire

// File: rtl/entry_pulse.sv
`default_nettype none
// ============================================================================
// Module      : entry_pulse
// Description : Registered one-cycle pulse in the cycle after i_active rises.
//               Held activity never re-fires the pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module entry_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic i_active,
  output logic o_pulse
);

  logic r_prev;
  logic r_pulse;

  // Remember last cycle's activity and fire on its rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_prev  <= i_active;
      r_pulse <= i_active & ~r_prev;
    end
  end

  assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/ctrl_bin_sched.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_bin_sched
// Description : Top-level bin scheduler. Walks bins in order (load, run core,
//               store), advances on partial SAT, backtracks across bins on
//               partial UNSAT, and reports global SAT/UNSAT and errors.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_bin_sched
  import sat_bin_pkg::*;
#(
  parameter int unsigned WIDTH_BIN_ID = c_DEF_WIDTH_BIN_ID,
  parameter int unsigned WIDTH_LVL    = c_DEF_WIDTH_LVL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_solver_i,
  input  logic [WIDTH_BIN_ID-1:0] num_bins_i,
  output logic                    done_solver_o,
  output logic                    sat_o,
  output logic                    unsat_o,
  output logic                    err_o,
  output logic [WIDTH_BIN_ID-1:0] cur_bin_num_o,
  output logic                    start_load_o,
  input  logic                    done_load_i,
  output logic                    start_core_o,
  input  logic                    done_core_i,
  input  logic                    core_sat_i,
  input  logic                    core_unsat_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_num_i,
  input  logic [WIDTH_LVL-1:0]    bkt_lvl_i,
  output logic                    start_store_o,
  input  logic                    done_store_i,
  output logic                    apply_bkt_gbl_o,
  output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
  input  logic                    done_bkt_gbl_i,
  output logic [31:0]             iter_cnt_o
);

  state_e                  r_state, w_state_nxt;
  dir_e                    r_dir, w_dir_nxt;
  logic [WIDTH_BIN_ID-1:0] r_cur, w_cur_nxt;
  logic [WIDTH_BIN_ID-1:0] r_num_bins;
  logic [WIDTH_BIN_ID-1:0] r_bkt_bin, w_bkt_bin_nxt;
  logic [WIDTH_LVL-1:0]    r_bkt_lvl, w_bkt_lvl_nxt;
  logic                    w_accept;
  logic                    w_enter_run;
  logic                    w_err_set;
  logic                    w_last_bin;
  logic                    r_sat, r_unsat, r_err, r_done;
  logic [31:0]             r_iter;
  logic [3:0]              w_cmd_active;
  logic [3:0]              w_cmd_pulse;

  // num_bins is never zero while this is consulted (zero goes straight to DONE_SAT).
  assign w_last_bin = (r_cur == (r_num_bins - WIDTH_BIN_ID'(1)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and next values of the walk registers.
  always_comb begin
    w_state_nxt   = r_state;
    w_dir_nxt     = r_dir;
    w_cur_nxt     = r_cur;
    w_bkt_bin_nxt = r_bkt_bin;
    w_bkt_lvl_nxt = r_bkt_lvl;
    w_accept      = 1'b0;
    w_enter_run   = 1'b0;
    w_err_set     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_solver_i) begin
          w_accept    = 1'b1;
          w_cur_nxt   = '0;
          w_state_nxt = (num_bins_i == '0) ? DONE_SAT : LOAD;
        end
      end
      LOAD: begin
        if (done_load_i) begin
          w_enter_run = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (done_core_i) begin
          // Unsat dominates sat; a result with neither flag is a protocol error.
          if (core_unsat_i) begin
            if (bkt_lvl_i == '0) begin
              w_state_nxt = DONE_UNSAT;
            end else if (bkt_bin_num_i > r_cur) begin
              w_err_set   = 1'b1;
              w_state_nxt = DONE_UNSAT;
            end else begin
              w_bkt_bin_nxt = bkt_bin_num_i;
              w_bkt_lvl_nxt = bkt_lvl_i;
              w_dir_nxt     = DIR_BKT;
              w_state_nxt   = STORE;
            end
          end else if (core_sat_i) begin
            w_dir_nxt   = DIR_FWD;
            w_state_nxt = STORE;
          end else begin
            w_err_set   = 1'b1;
            w_state_nxt = DONE_UNSAT;
          end
        end
      end
      STORE: begin
        if (done_store_i) begin
          if (r_dir == DIR_BKT) begin
            w_state_nxt = BKT_GBL;
          end else if (w_last_bin) begin
            w_state_nxt = DONE_SAT;
          end else begin
            w_cur_nxt   = r_cur + WIDTH_BIN_ID'(1);
            w_state_nxt = LOAD;
          end
        end
      end
      BKT_GBL: begin
        if (done_bkt_gbl_i) begin
          w_cur_nxt   = r_bkt_bin;
          w_state_nxt = LOAD;
        end
      end
      DONE_SAT:   w_state_nxt = IDLE;
      DONE_UNSAT: w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Walk registers, result flags and the iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir      <= DIR_FWD;
      r_cur      <= '0;
      r_num_bins <= '0;
      r_bkt_bin  <= '0;
      r_bkt_lvl  <= '0;
      r_sat      <= 1'b0;
      r_unsat    <= 1'b0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_iter     <= '0;
    end else begin
      r_dir     <= w_dir_nxt;
      r_cur     <= w_cur_nxt;
      r_bkt_bin <= w_bkt_bin_nxt;
      r_bkt_lvl <= w_bkt_lvl_nxt;
      r_done    <= (r_state == DONE_SAT) || (r_state == DONE_UNSAT);
      if (w_accept) begin
        r_num_bins <= num_bins_i;
        r_sat      <= 1'b0;
        r_unsat    <= 1'b0;
        r_err      <= 1'b0;
        r_iter     <= '0;
      end
      if (w_err_set) r_err <= 1'b1;
      if (w_enter_run && (r_iter != 32'hFFFF_FFFF)) r_iter <= r_iter + 32'd1;
      if (r_state == DONE_SAT) begin
        r_sat   <= 1'b1;
        r_unsat <= 1'b0;
      end
      if (r_state == DONE_UNSAT) begin
        r_sat   <= 1'b0;
        r_unsat <= 1'b1;
      end
    end
  end

  // One registered command pulse per command state: load, core, store, backtrack.
  assign w_cmd_active = {r_state == BKT_GBL, r_state == STORE, r_state == RUN, r_state == LOAD};

  for (genvar gi = 0; gi < 4; gi++) begin : g_cmd_pulse
    entry_pulse u_entry_pulse (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_active (w_cmd_active[gi]),
      .o_pulse  (w_cmd_pulse[gi])
    );
  end

  assign start_load_o    = w_cmd_pulse[0];
  assign start_core_o    = w_cmd_pulse[1];
  assign start_store_o   = w_cmd_pulse[2];
  assign apply_bkt_gbl_o = w_cmd_pulse[3];
  assign done_solver_o   = r_done;
  assign sat_o           = r_sat;
  assign unsat_o         = r_unsat;
  assign err_o           = r_err;
  assign cur_bin_num_o   = r_cur;
  assign bkt_lvl_o       = r_bkt_lvl;
  assign iter_cnt_o      = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_bin_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_bin_sched
// Description : Scoreboard bench for ctrl_bin_sched. Directed tests push the
//               expected command/result events; a monitor pops and compares
//               each pulse the DUT issues. A behavioural engine answers the
//               load/core/store/backtrack commands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_bin_sched;

  localparam int c_WB = 10;
  localparam int c_WL = 16;

  localparam logic [2:0] c_K_LOAD  = 3'd0;
  localparam logic [2:0] c_K_CORE  = 3'd1;
  localparam logic [2:0] c_K_STORE = 3'd2;
  localparam logic [2:0] c_K_BKT   = 3'd3;
  localparam logic [2:0] c_K_DONE  = 3'd4;

  localparam logic [31:0] c_R_SAT     = 32'b100;
  localparam logic [31:0] c_R_UNSAT   = 32'b010;
  localparam logic [31:0] c_R_UNS_ERR = 32'b011;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  typedef struct packed {
    logic            sat;
    logic            unsat;
    logic [c_WB-1:0] bin;
    logic [c_WL-1:0] lvl;
  } core_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_solver_i = 1'b0;
  logic [c_WB-1:0] num_bins_i = '0;
  logic            done_solver_o, sat_o, unsat_o, err_o;
  logic [c_WB-1:0] cur_bin_num_o;
  logic            start_load_o, start_core_o, start_store_o, apply_bkt_gbl_o;
  logic            done_load_i = 1'b0;
  logic            done_core_i = 1'b0;
  logic            core_sat_i = 1'b0;
  logic            core_unsat_i = 1'b0;
  logic [c_WB-1:0] bkt_bin_num_i = '0;
  logic [c_WL-1:0] bkt_lvl_i = '0;
  logic            done_store_i = 1'b0;
  logic [c_WL-1:0] bkt_lvl_o;
  logic            done_bkt_gbl_i = 1'b0;
  logic [31:0]     iter_cnt_o;

  ev_t   exp_q[$];
  core_t core_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    bkt_lat = 1;

  ctrl_bin_sched #(.WIDTH_BIN_ID(c_WB), .WIDTH_LVL(c_WL)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_solver_i  (start_solver_i),
    .num_bins_i      (num_bins_i),
    .done_solver_o   (done_solver_o),
    .sat_o           (sat_o),
    .unsat_o         (unsat_o),
    .err_o           (err_o),
    .cur_bin_num_o   (cur_bin_num_o),
    .start_load_o    (start_load_o),
    .done_load_i     (done_load_i),
    .start_core_o    (start_core_o),
    .done_core_i     (done_core_i),
    .core_sat_i      (core_sat_i),
    .core_unsat_i    (core_unsat_i),
    .bkt_bin_num_i   (bkt_bin_num_i),
    .bkt_lvl_i       (bkt_lvl_i),
    .start_store_o   (start_store_o),
    .done_store_i    (done_store_i),
    .apply_bkt_gbl_o (apply_bkt_gbl_o),
    .bkt_lvl_o       (bkt_lvl_o),
    .done_bkt_gbl_i  (done_bkt_gbl_i),
    .iter_cnt_o      (iter_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic string kname(logic [2:0] k);
    case (k)
      c_K_LOAD:  return "load";
      c_K_CORE:  return "core";
      c_K_STORE: return "store";
      c_K_BKT:   return "bkt";
      default:   return "done";
    endcase
  endfunction

  task automatic check(string name, logic [71:0] got, logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_ev(logic [2:0] k, logic [31:0] a, logic [31:0] b);
    ev_t e;
    e.kind = k;
    e.a    = a;
    e.b    = b;
    exp_q.push_back(e);
  endtask

  // Expected events for one pass over a bin: load, core run, optional store.
  task automatic exp_bin(int bin, bit with_store);
    push_ev(c_K_LOAD, 32'(bin), 32'd0);
    push_ev(c_K_CORE, 32'(bin), 32'd0);
    if (with_store) push_ev(c_K_STORE, 32'(bin), 32'd0);
  endtask

  task automatic push_core(bit s, bit u, int bin, int lvl);
    core_t c;
    c.sat   = s;
    c.unsat = u;
    c.bin   = c_WB'(bin);
    c.lvl   = c_WL'(lvl);
    core_q.push_back(c);
  endtask

  task automatic observe(logic [2:0] k, logic [31:0] a, logic [31:0] b);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_%s: got a=%0h b=%0h expected no event", kname(k), a, b);
    end else begin
      e = exp_q.pop_front();
      check({"ev_", kname(e.kind)}, {5'd0, k, a, b}, {5'd0, e.kind, e.a, e.b});
    end
  endtask

  // Monitor: every command pulse and the done pulse are matched in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (start_load_o)    observe(c_K_LOAD, 32'(cur_bin_num_o), 32'd0);
      if (start_core_o)    observe(c_K_CORE, 32'(cur_bin_num_o), 32'd0);
      if (start_store_o)   observe(c_K_STORE, 32'(cur_bin_num_o), 32'd0);
      if (apply_bkt_gbl_o) observe(c_K_BKT, 32'(bkt_lvl_o), 32'(cur_bin_num_o));
      if (done_solver_o)   observe(c_K_DONE, {29'd0, sat_o, unsat_o, err_o}, iter_cnt_o);
    end
  end

  // Engine model: load responder.
  initial forever begin
    @(negedge clk);
    if (start_load_o) begin
      @(negedge clk);
      done_load_i = 1'b1;
      @(negedge clk);
      done_load_i = 1'b0;
    end
  end

  // Engine model: core responder, answers from the scripted result queue.
  initial forever begin
    @(negedge clk);
    if (start_core_o) begin
      core_t c;
      if (core_q.size() != 0) c = core_q.pop_front();
      else c = '{sat: 1'b0, unsat: 1'b1, bin: '0, lvl: '0};
      @(negedge clk);
      done_core_i   = 1'b1;
      core_sat_i    = c.sat;
      core_unsat_i  = c.unsat;
      bkt_bin_num_i = c.bin;
      bkt_lvl_i     = c.lvl;
      @(negedge clk);
      done_core_i   = 1'b0;
      core_sat_i    = 1'b0;
      core_unsat_i  = 1'b0;
      bkt_bin_num_i = '0;
      bkt_lvl_i     = '0;
    end
  end

  // Engine model: store responder.
  initial forever begin
    @(negedge clk);
    if (start_store_o) begin
      @(negedge clk);
      done_store_i = 1'b1;
      @(negedge clk);
      done_store_i = 1'b0;
    end
  end

  // Engine model: global backtrack responder with adjustable latency.
  initial forever begin
    @(negedge clk);
    if (apply_bkt_gbl_o) begin
      repeat (bkt_lat) @(negedge clk);
      done_bkt_gbl_i = 1'b1;
      @(negedge clk);
      done_bkt_gbl_i = 1'b0;
    end
  end

  task automatic start_solve(int n);
    num_bins_i     = c_WB'(n);
    start_solver_i = 1'b1;
    @(negedge clk);
    start_solver_i = 1'b0;
  endtask

  task automatic wait_done(string name, int bound);
    int k = 0;
    while (!done_solver_o && k < bound) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done_seen"}, 72'(done_solver_o), 72'd1);
  endtask

  task automatic end_test(string name);
    repeat (2) @(negedge clk);
    check({name, "_events_left"}, 72'(exp_q.size()), 72'd0);
    check({name, "_core_left"}, 72'(core_q.size()), 72'd0);
    exp_q.delete();
    core_q.delete();
  endtask

  function automatic logic [71:0] all_outs();
    return 72'({done_solver_o, sat_o, unsat_o, err_o, start_load_o, start_core_o,
                start_store_o, apply_bkt_gbl_o, cur_bin_num_o, bkt_lvl_o, iter_cnt_o});
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 72'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: three bins, all sat.
    for (int b = 0; b < 3; b++) begin
      exp_bin(b, 1'b1);
      push_core(1'b1, 1'b0, 0, 0);
    end
    push_ev(c_K_DONE, c_R_SAT, 32'd3);
    start_solve(3);
    check("t1_load_cycle1_low", 72'(start_load_o), 72'd0);
    @(negedge clk);
    check("t1_load_cycle2_high", 72'(start_load_o), 72'd1);
    wait_done("t1", 400);
    end_test("t1");

    // T2: unsat on bin 2 backtracks to bin 0 at level 5, then all sat.
    exp_bin(0, 1'b1); exp_bin(1, 1'b1); exp_bin(2, 1'b1);
    push_ev(c_K_BKT, 32'd5, 32'd2);
    exp_bin(0, 1'b1); exp_bin(1, 1'b1); exp_bin(2, 1'b1);
    push_ev(c_K_DONE, c_R_SAT, 32'd6);
    push_core(1'b1, 1'b0, 0, 0); push_core(1'b1, 1'b0, 0, 0);
    push_core(1'b0, 1'b1, 0, 5);
    push_core(1'b1, 1'b0, 0, 0); push_core(1'b1, 1'b0, 0, 0); push_core(1'b1, 1'b0, 0, 0);
    start_solve(3);
    wait_done("t2", 600);
    end_test("t2");

    // T3: unsat at level 0 on bin 1 ends with no store, no error.
    exp_bin(0, 1'b1); exp_bin(1, 1'b0);
    push_ev(c_K_DONE, c_R_UNSAT, 32'd2);
    push_core(1'b1, 1'b0, 0, 0); push_core(1'b0, 1'b1, 0, 0);
    start_solve(3);
    wait_done("t3", 400);
    end_test("t3");

    // T4: backtrack target ahead of the current bin is an error.
    exp_bin(0, 1'b1); exp_bin(1, 1'b0);
    push_ev(c_K_DONE, c_R_UNS_ERR, 32'd2);
    push_core(1'b1, 1'b0, 0, 0); push_core(1'b0, 1'b1, 4, 3);
    start_solve(3);
    wait_done("t4", 400);
    end_test("t4");

    // T5: sat and unsat together take the backtrack path (same bin), err cleared.
    exp_bin(0, 1'b1);
    push_ev(c_K_BKT, 32'd2, 32'd0);
    exp_bin(0, 1'b1); exp_bin(1, 1'b1);
    push_ev(c_K_DONE, c_R_SAT, 32'd3);
    push_core(1'b1, 1'b1, 0, 2); push_core(1'b1, 1'b0, 0, 0); push_core(1'b1, 1'b0, 0, 0);
    start_solve(2);
    wait_done("t5", 400);
    end_test("t5");

    // T6: zero bins finishes sat within 3 cycles with no load.
    push_ev(c_K_DONE, c_R_SAT, 32'd0);
    start_solve(0);
    wait_done("t6", 3);
    end_test("t6");

    // T7: neither result flag set is treated as an erroneous unsat.
    exp_bin(0, 1'b0);
    push_ev(c_K_DONE, c_R_UNS_ERR, 32'd1);
    push_core(1'b0, 1'b0, 0, 0);
    start_solve(1);
    wait_done("t7", 400);
    end_test("t7");

    // T8: asynchronous reset while waiting in BKT_GBL.
    bkt_lat = 20;
    exp_bin(0, 1'b1); exp_bin(1, 1'b1);
    push_ev(c_K_BKT, 32'd3, 32'd1);
    push_core(1'b1, 1'b0, 0, 0); push_core(1'b0, 1'b1, 0, 3);
    start_solve(2);
    begin
      int k = 0;
      while (!apply_bkt_gbl_o && k < 400) begin
        @(negedge clk);
        k++;
      end
      check("t8_bkt_seen", 72'(apply_bkt_gbl_o), 72'd1);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t8_reset_immediate", all_outs(), 72'd0);
    repeat (2) @(negedge clk);
    check("t8_reset_held", all_outs(), 72'd0);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("t8_idle_after_reset", all_outs(), 72'd0);
    end_test("t8");
    bkt_lat = 1;

    // T9: a fresh start after reset completes normally.
    exp_bin(0, 1'b1); exp_bin(1, 1'b1);
    push_ev(c_K_DONE, c_R_SAT, 32'd2);
    push_core(1'b1, 1'b0, 0, 0); push_core(1'b1, 1'b0, 0, 0);
    start_solve(2);
    wait_done("t9", 400);
    end_test("t9");
    check("t9_sat_held", 72'({sat_o, unsat_o}), 72'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
